// File: rtl/sop_seq_eval_pkg.sv
// Shared types and helpers for the sum-of-products sequential evaluator.
// Holds the engine state encoding and the product-term match rule.
package sop_eval_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // Widest input vector the match helper accepts; narrower vectors are zero-extended.
  localparam int unsigned SOP_VEC_W = 32;

  // A slot matches when it is enabled and every cared bit equals its required value.
  function automatic logic sop_term_match(input logic                 en,
                                          input logic [SOP_VEC_W-1:0] vec,
                                          input logic [SOP_VEC_W-1:0] care,
                                          input logic [SOP_VEC_W-1:0] val);
    return en && (((vec ^ val) & care) == {SOP_VEC_W{1'b0}});
  endfunction

endpackage

// File: rtl/sop_seq_eval_term_table.sv
// Product-term table: N_TERMS slots of {en, care, val}, one write port,
// one combinational read port addressed by the scan index.
module sop_term_table #(
  parameter int N_IN    = 4,
  parameter int N_TERMS = 4,
  parameter int IDX_W   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic             en_i,
  input  logic [N_IN-1:0]  care_i,
  input  logic [N_IN-1:0]  val_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic             en_o,
  output logic [N_IN-1:0]  care_o,
  output logic [N_IN-1:0]  val_o
);

  typedef struct packed {
    logic            en;
    logic [N_IN-1:0] care;
    logic [N_IN-1:0] val;
  } term_t;

  term_t slot_q [N_TERMS];

  // Slot storage: cleared on reset, written only for in-range addresses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_TERMS; i++) begin
        slot_q[i] <= '0;
      end
    end else if (we_i && (int'(waddr_i) < N_TERMS)) begin
      slot_q[waddr_i] <= '{en: en_i, care: care_i, val: val_i};
    end
  end

  assign en_o   = slot_q[raddr_i].en;
  assign care_o = slot_q[raddr_i].care;
  assign val_o  = slot_q[raddr_i].val;

endmodule

// File: rtl/sop_seq_eval.sv
// Programmable sum-of-products evaluator. A captured input vector is compared
// against one product-term slot per clock; the first enabled matching slot ends
// the scan. Result is held with valid/ready until consumed.
// Optional build macro SOP_HIT_COUNT_EN: scan all slots every time and report
// the number of matching slots on out_hit_cnt_o (lowest hit on out_hit_idx_o).
module sop_seq_eval
  import sop_eval_pkg::*;
#(
  parameter int N_IN    = 4,
  parameter int N_TERMS = 4,
  localparam int IDX_W  = (N_TERMS > 1) ? $clog2(N_TERMS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we_i,
  input  logic [IDX_W-1:0] cfg_addr_i,
  input  logic             cfg_en_i,
  input  logic [N_IN-1:0]  cfg_care_i,
  input  logic [N_IN-1:0]  cfg_val_i,
  output logic             cfg_busy_o,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [N_IN-1:0]  in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             out_bit_o,
  output logic [IDX_W-1:0] out_hit_idx_o
`ifdef SOP_HIT_COUNT_EN
  ,
  output logic [$clog2(N_TERMS+1)-1:0] out_hit_cnt_o
`endif
);

`ifdef SOP_HIT_COUNT_EN
  localparam int CNT_W = $clog2(N_TERMS + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  state_e           state_q, state_d;
  logic [N_IN-1:0]  in_q, in_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             out_bit_q, out_bit_d;
  logic [IDX_W-1:0] hit_idx_q, hit_idx_d;
  logic             out_valid_q, out_valid_d;

  logic             t_en_s;
  logic [N_IN-1:0]  t_care_s;
  logic [N_IN-1:0]  t_val_s;
  logic             table_we_s;
  logic             match_s;
  logic             last_s;

  // The table may only change while no evaluation is in flight.
  assign table_we_s = cfg_we_i && (state_q == IDLE);

  sop_term_table #(
    .N_IN    (N_IN),
    .N_TERMS (N_TERMS),
    .IDX_W   (IDX_W)
  ) u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (table_we_s),
    .waddr_i (cfg_addr_i),
    .en_i    (cfg_en_i),
    .care_i  (cfg_care_i),
    .val_i   (cfg_val_i),
    .raddr_i (idx_q),
    .en_o    (t_en_s),
    .care_o  (t_care_s),
    .val_o   (t_val_s)
  );

  assign match_s = sop_term_match(t_en_s, SOP_VEC_W'(in_q), SOP_VEC_W'(t_care_s),
                                  SOP_VEC_W'(t_val_s));
  assign last_s  = (idx_q == IDX_W'(N_TERMS - 1));

  // Next-state and result logic for the IDLE -> SCAN -> DONE sequence.
  always_comb begin
    state_d     = state_q;
    in_d        = in_q;
    idx_d       = idx_q;
    out_bit_d   = out_bit_q;
    hit_idx_d   = hit_idx_q;
    out_valid_d = 1'b0;
`ifdef SOP_HIT_COUNT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          in_d      = in_data_i;
          idx_d     = {IDX_W{1'b0}};
          out_bit_d = 1'b0;
          hit_idx_d = {IDX_W{1'b0}};
`ifdef SOP_HIT_COUNT_EN
          cnt_d     = {CNT_W{1'b0}};
`endif
          state_d   = SCAN;
        end else begin
          state_d   = IDLE;
        end
      end
      SCAN: begin
`ifdef SOP_HIT_COUNT_EN
        if (match_s) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == {CNT_W{1'b0}}) begin
            out_bit_d = 1'b1;
            hit_idx_d = idx_q;
          end else begin
            out_bit_d = out_bit_q;
          end
        end else begin
          cnt_d = cnt_q;
        end
        if (last_s) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
        end
`else
        if (match_s) begin
          out_bit_d = 1'b1;
          hit_idx_d = idx_q;
          state_d   = DONE;
        end else if (last_s) begin
          out_bit_d = 1'b0;
          hit_idx_d = {IDX_W{1'b0}};
          state_d   = DONE;
        end else begin
          idx_d     = idx_q + IDX_W'(1);
        end
`endif
      end
      DONE: begin
        // out_valid rises one cycle after entering DONE and drops on handshake.
        if (out_valid_q && out_ready_i) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_q        <= {N_IN{1'b0}};
      idx_q       <= {IDX_W{1'b0}};
      out_bit_q   <= 1'b0;
      hit_idx_q   <= {IDX_W{1'b0}};
      out_valid_q <= 1'b0;
`ifdef SOP_HIT_COUNT_EN
      cnt_q       <= {CNT_W{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      in_q        <= in_d;
      idx_q       <= idx_d;
      out_bit_q   <= out_bit_d;
      hit_idx_q   <= hit_idx_d;
      out_valid_q <= out_valid_d;
`ifdef SOP_HIT_COUNT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign in_ready_o    = (state_q == IDLE);
  assign cfg_busy_o    = (state_q != IDLE);
  assign out_valid_o   = out_valid_q;
  assign out_bit_o     = out_bit_q;
  assign out_hit_idx_o = hit_idx_q;
`ifdef SOP_HIT_COUNT_EN
  assign out_hit_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_sop_seq_eval.sv
// Scoreboard bench for sop_seq_eval: the driver pushes expected results from a
// table-scan reference model; an independent monitor pops and compares them.
module tb_sop_seq_eval;

  localparam int N_IN    = 4;
  localparam int N_TERMS = 4;
  localparam int IDX_W   = 2;
  localparam int CNT_W   = $clog2(N_TERMS + 1);

  logic             clk;
  logic             rst_n;
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_addr;
  logic             cfg_en;
  logic [N_IN-1:0]  cfg_care;
  logic [N_IN-1:0]  cfg_val;
  logic             cfg_busy;
  logic             in_valid;
  logic             in_ready;
  logic [N_IN-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_bit;
  logic [IDX_W-1:0] out_hit_idx;
`ifdef SOP_HIT_COUNT_EN
  logic [CNT_W-1:0] out_hit_cnt;
`endif

  sop_seq_eval #(.N_IN(N_IN), .N_TERMS(N_TERMS)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_we_i      (cfg_we),
    .cfg_addr_i    (cfg_addr),
    .cfg_en_i      (cfg_en),
    .cfg_care_i    (cfg_care),
    .cfg_val_i     (cfg_val),
    .cfg_busy_o    (cfg_busy),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_data_i     (in_data),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_bit_o     (out_bit),
    .out_hit_idx_o (out_hit_idx)
`ifdef SOP_HIT_COUNT_EN
    ,
    .out_hit_cnt_o (out_hit_cnt)
`endif
  );

  typedef struct {
    bit b;
    int idx;
    int cnt;
    int lat;
    int acc;
  } exp_t;

  exp_t sb_q[$];

  bit              m_en   [N_TERMS];
  logic [N_IN-1:0] m_care [N_TERMS];
  logic [N_IN-1:0] m_val  [N_TERMS];

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  bit stall_req = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: walk the table in order, every cared bit must equal the stored value.
  function automatic exp_t model(input logic [N_IN-1:0] d);
    exp_t e;
    int first = -1;
    e.cnt = 0;
    for (int i = 0; i < N_TERMS; i++) begin
      if (m_en[i] && ((d & m_care[i]) == (m_val[i] & m_care[i]))) begin
        e.cnt++;
        if (first < 0) first = i;
      end
    end
    e.b   = (first >= 0);
    e.idx = (first >= 0) ? first : 0;
`ifdef SOP_HIT_COUNT_EN
    e.lat = N_TERMS + 1;
`else
    e.lat = (first >= 0) ? first + 2 : N_TERMS + 1;
`endif
    e.acc = 0;
    return e;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N_TERMS; i++) begin
      m_en[i] = 1'b0; m_care[i] = '0; m_val[i] = '0;
    end
  endtask

  task automatic model_write(input int a, input bit en, input logic [N_IN-1:0] c,
                             input logic [N_IN-1:0] v);
    if (a < N_TERMS) begin
      m_en[a] = en; m_care[a] = c; m_val[a] = v;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      $display("FAIL idle_wait: in_ready stayed %0b, required 1 within 200 cycles", in_ready);
    end
  endtask

  task automatic cfg_write(input int a, input bit en, input logic [N_IN-1:0] c,
                           input logic [N_IN-1:0] v);
    wait_idle();
    cfg_we = 1'b1; cfg_addr = IDX_W'(a); cfg_en = en; cfg_care = c; cfg_val = v;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    model_write(a, en, c, v);
  endtask

  task automatic send(input logic [N_IN-1:0] d, input bit wr, input int a, input bit en,
                      input logic [N_IN-1:0] c, input logic [N_IN-1:0] v);
    exp_t e;
    wait_idle();
    in_valid = 1'b1; in_data = d;
    if (wr) begin
      cfg_we = 1'b1; cfg_addr = IDX_W'(a); cfg_en = en; cfg_care = c; cfg_val = v;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_we = 1'b0;
    if (wr) model_write(a, en, c, v);
    e = model(d);
    e.acc = cyc;
    sb_q.push_back(e);
  endtask

  // Monitor: latency on first valid, stability while stalled, values on handshake.
  bit              seen = 0;
  bit              chk_idle = 0;
  int              stall_left = 0;
  logic            cap_bit;
  logic [IDX_W-1:0] cap_idx;
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 0; chk_idle = 0; stall_left = 0; out_ready = 1'b1;
    end else begin
      if (chk_idle) begin
        check("idle_after_handshake", in_ready, 1);
        chk_idle = 0;
      end
      if (out_valid) begin
        if (!seen) begin
          seen = 1; cap_bit = out_bit; cap_idx = out_hit_idx;
          if (sb_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_output: out_valid=1 with no pending result");
          end else begin
            check("latency", cyc - sb_q[0].acc, sb_q[0].lat);
          end
          if (stall_req) begin
            stall_left = 6; stall_req = 0;
          end
        end else begin
          check("stable_bit", out_bit, cap_bit);
          check("stable_idx", out_hit_idx, cap_idx);
          check("in_ready_in_done", in_ready, 0);
        end
        if (stall_left > 0) begin
          out_ready = 1'b0; stall_left--;
        end else begin
          out_ready = ($urandom_range(0, 3) != 0);
        end
        if (out_ready && sb_q.size() != 0) begin
          check("out_bit", out_bit, sb_q[0].b);
          check("out_hit_idx", out_hit_idx, sb_q[0].idx);
`ifdef SOP_HIT_COUNT_EN
          check("out_hit_cnt", out_hit_cnt, sb_q[0].cnt);
`endif
          void'(sb_q.pop_front());
          seen = 0; chk_idle = 1;
        end else if (out_ready) begin
          seen = 0;
        end
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_en = 1'b0; cfg_care = '0; cfg_val = '0;
    in_valid = 1'b0; in_data = '0;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_cfg_busy", cfg_busy, 0);
    check("rst_out_bit", out_bit, 0);
    check("rst_hit_idx", out_hit_idx, 0);
`ifdef SOP_HIT_COUNT_EN
    check("rst_hit_cnt", out_hit_cnt, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table from the reference gate network.
    cfg_write(0, 1'b1, 4'b1111, 4'b1000);
    cfg_write(1, 1'b1, 4'b1101, 4'b1101);
    cfg_write(2, 1'b1, 4'b1110, 4'b1110);
    cfg_write(3, 1'b1, 4'b1011, 4'b0011);
    send(4'b1000, 1'b0, 0, 1'b0, 4'b0000, 4'b0000);
    send(4'b0011, 1'b0, 0, 1'b0, 4'b0000, 4'b0000);
    send(4'b0000, 1'b0, 0, 1'b0, 4'b0000, 4'b0000);

    // Consumer stall in DONE.
    stall_req = 1'b1;
    send(4'b0011, 1'b0, 0, 1'b0, 4'b0000, 4'b0000);

    // Write attempted while scanning must be dropped.
    send(4'b1000, 1'b0, 0, 1'b0, 4'b0000, 4'b0000);
    check("cfg_busy_in_scan", cfg_busy, 1);
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_en = 1'b0; cfg_care = 4'b0000; cfg_val = 4'b0000;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    send(4'b1000, 1'b0, 0, 1'b0, 4'b0000, 4'b0000);

    // Write coincident with accept lands before the first compare.
    send(4'b0000, 1'b1, 1, 1'b1, 4'b0000, 4'b0101);

    // Randomised table and vectors.
    for (int i = 0; i < N_TERMS; i++)
      cfg_write(i, 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom));
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 4) == 0)
        cfg_write(int'($urandom_range(0, N_TERMS - 1)), 1'($urandom_range(0, 1)),
                  4'($urandom), 4'($urandom));
      send(4'($urandom), ($urandom_range(0, 5) == 0), int'($urandom_range(0, N_TERMS - 1)),
           1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom));
    end

    // Reset in the middle of a full-length scan.
    for (int i = 0; i < N_TERMS; i++) cfg_write(i, 1'b1, 4'b1111, 4'b1111);
    send(4'b0000, 1'b0, 0, 1'b0, 4'b0000, 4'b0000);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_cfg_busy", cfg_busy, 0);
    sb_q.delete();
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(4'b1111, 1'b0, 0, 1'b0, 4'b0000, 4'b0000);
    send(4'($urandom), 1'b0, 0, 1'b0, 4'b0000, 4'b0000);

    // Two don't-care slots: counting build reports both, default stops at slot 0.
    cfg_write(0, 1'b1, 4'b0000, 4'b0000);
    cfg_write(2, 1'b1, 4'b0000, 4'b0000);
    send(4'b0110, 1'b0, 0, 1'b0, 4'b0000, 4'b0000);

    begin
      int n = 0;
      while (sb_q.size() != 0 && n < 500) begin
        @(negedge clk);
        n++;
      end
      if (sb_q.size() != 0) begin
        total++;
        $display("FAIL drain: %0d results outstanding, required 0", sb_q.size());
      end
    end
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
